mux_serializer_ctrl: RTL and testbench



---
 rtl/mux_serializer_ctrl.sv | 108 ++++++++++
 tb/tb_mux_serializer_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mux_serializer_ctrl.sv
// Drives an 8:1 mux (D/S/EN) one select per clock, samples its Y output back into a
// serial stream and a loopback capture word, and flags a launch/capture mismatch.
module mux_serializer_ctrl #(
    parameter bit          LSB_FIRST  = 1'b1,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic [7:0] DIN,
    output logic       BUSY,
    output logic [7:0] D,
    output logic [2:0] S,
    output logic       EN,
    input  logic       Y,
    output logic       SOUT,
    output logic       SVALID,
    output logic       DONE,
    output logic [7:0] RXWORD,
    output logic       ERR
);

    localparam logic [2:0] FirstIdx = LSB_FIRST ? 3'd0 : 3'd7;
    localparam logic [2:0] LastIdx  = LSB_FIRST ? 3'd7 : 3'd0;
    // Counter is preloaded with GAP_CYCLES-1 so GAP lasts exactly GAP_CYCLES cycles.
    localparam logic [3:0] GapLoad  = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StShift, StFinish, StGap} state_e;

    state_e     state;
    logic [3:0] gap_cnt;
    logic [7:0] rx_next;

    // Capture word with the current mux sample merged in, so ERR can see the last bit.
    always_comb begin
        rx_next    = RXWORD;
        rx_next[S] = Y;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= StIdle;
            gap_cnt <= 4'd0;
            D       <= 8'd0;
            S       <= 3'd0;
            EN      <= 1'b1;
            SOUT    <= 1'b0;
            SVALID  <= 1'b0;
            DONE    <= 1'b0;
            BUSY    <= 1'b0;
            RXWORD  <= 8'd0;
            ERR     <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    EN     <= 1'b1;
                    SVALID <= 1'b0;
                    if (START) begin
                        D      <= DIN;
                        S      <= FirstIdx;
                        EN     <= 1'b0;
                        BUSY   <= 1'b1;
                        RXWORD <= 8'd0;
                        ERR    <= 1'b0;
                        state  <= StShift;
                    end
                end
                StShift: begin
                    SOUT   <= Y;
                    SVALID <= 1'b1;
                    RXWORD <= rx_next;
                    if (S == LastIdx) begin
                        EN    <= 1'b1;
                        DONE  <= 1'b1;
                        ERR   <= (rx_next != D);
                        state <= StFinish;
                    end else if (LSB_FIRST) begin
                        S <= S + 3'd1;
                    end else begin
                        S <= S - 3'd1;
                    end
                end
                StFinish: begin
                    DONE   <= 1'b0;
                    SVALID <= 1'b0;
                    if (GAP_CYCLES == 0) begin
                        BUSY  <= 1'b0;
                        state <= StIdle;
                    end else begin
                        gap_cnt <= GapLoad;
                        state   <= StGap;
                    end
                end
                StGap: begin
                    EN <= 1'b1;
                    if (gap_cnt == 4'd0) begin
                        BUSY  <= 1'b0;
                        state <= StIdle;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_serializer_ctrl.sv
// Bench for mux_serializer_ctrl: two instances (LSB-first/no gap, MSB-first/gap 2), each
// looped through a behavioural 8:1 mux with an optional stuck-at-0 fault on select 3.
module tb_mux_serializer_ctrl;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            fault;
    logic [1:0]      start, busy, en, y, sout, svalid, done, err;
    logic [1:0][7:0] din, d, rxword;
    logic [1:0][2:0] s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_serializer_ctrl #(.LSB_FIRST(1'b1), .GAP_CYCLES(0)) dut_lsb (
        .CLK(clk), .RST_N(rst_n), .START(start[0]), .DIN(din[0]), .BUSY(busy[0]), .D(d[0]),
        .S(s[0]), .EN(en[0]), .Y(y[0]), .SOUT(sout[0]), .SVALID(svalid[0]), .DONE(done[0]),
        .RXWORD(rxword[0]), .ERR(err[0])
    );

    mux_serializer_ctrl #(.LSB_FIRST(1'b0), .GAP_CYCLES(2)) dut_msb (
        .CLK(clk), .RST_N(rst_n), .START(start[1]), .DIN(din[1]), .BUSY(busy[1]), .D(d[1]),
        .S(s[1]), .EN(en[1]), .Y(y[1]), .SOUT(sout[1]), .SVALID(svalid[1]), .DONE(done[1]),
        .RXWORD(rxword[1]), .ERR(err[1])
    );

    // Gate-level mux behaviour: active-low enable, optional stuck-at-0 on input 3.
    assign y[0] = en[0] ? 1'b0 : ((fault && s[0] == 3'd3) ? 1'b0 : d[0][s[0]]);
    assign y[1] = en[1] ? 1'b0 : ((fault && s[1] == 3'd3) ? 1'b0 : d[1][s[1]]);

    typedef struct {
        int         u;
        logic [7:0] w;
        bit         flt;
        logic [7:0] exp_rx;
        bit         exp_err;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Mux index visited for the i-th serial bit.
    function automatic int idx(input int u, input int i);
        return (u == 0) ? i : 7 - i;
    endfunction

    // Entered and left at a negedge; on exit the unit is idle and may restart immediately.
    task automatic run_word(input int u, input logic [7:0] w, input bit flt,
                            input logic [7:0] exp_rx, input bit exp_err);
        int gap;
        gap   = (u == 0) ? 0 : 2;
        fault = flt;
        start[u] = 1'b1;
        din[u]   = w;
        @(negedge clk);
        start[u] = 1'b0;
        din[u]   = 8'($urandom);
        chk("busy_accept", busy[u], 1);
        chk("err_clear", err[u], 0);
        chk("rx_clear", rxword[u], 0);
        chk("d_load", d[u], w);
        for (int i = 0; i < 8; i++) begin
            chk("s_walk", s[u], idx(u, i));
            chk("en_low", en[u], 0);
            @(negedge clk);
            chk("sout", sout[u], exp_rx[idx(u, i)]);
            chk("svalid", svalid[u], 1);
            chk("done", done[u], (i == 7) ? 1 : 0);
        end
        chk("rxword", rxword[u], exp_rx);
        chk("err", err[u], exp_err);
        chk("en_done", en[u], 1);
        for (int n = 1; n <= gap + 1; n++) begin
            @(negedge clk);
            chk("busy_tail", busy[u], (n <= gap) ? 1 : 0);
            chk("svalid_tail", svalid[u], 0);
            chk("done_tail", done[u], 0);
            chk("en_tail", en[u], 1);
            chk("err_hold", err[u], exp_err);
        end
        chk("d_hold", d[u], w);
        fault = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] dins[36];
        logic [7:0] asm_word;
        logic [7:0] w, rx;
        bit         flt;
        int         u, ph;

        rst_n = 1'b0;
        fault = 1'b0;
        start = '0;
        din   = '0;

        tbl[0] = '{0, 8'hA5, 1'b0, 8'hA5, 1'b0};
        tbl[1] = '{1, 8'h3C, 1'b0, 8'h3C, 1'b0};
        tbl[2] = '{1, 8'hFF, 1'b1, 8'hF7, 1'b1};
        tbl[3] = '{0, 8'h00, 1'b1, 8'h00, 1'b0};
        tbl[4] = '{0, 8'h08, 1'b1, 8'h00, 1'b1};
        tbl[5] = '{1, 8'h81, 1'b0, 8'h81, 1'b0};

        // Reset then idle.
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("idle_en", en, 2'b11);
            chk("idle_s", s, 0);
            chk("idle_flags", {busy, sout, svalid, done, err}, 0);
            chk("idle_words", {d, rxword}, 0);
        end

        for (int t = 0; t < 6; t++)
            run_word(tbl[t].u, tbl[t].w, tbl[t].flt, tbl[t].exp_rx, tbl[t].exp_err);

        // ERR raised by a faulty word holds through idle until the next START.
        run_word(0, 8'hFF, 1'b1, 8'hF7, 1'b1);
        repeat (5) begin
            @(negedge clk);
            chk("err_idle_hold", err[0], 1);
            chk("rx_idle_hold", rxword[0], 8'hF7);
        end
        run_word(0, 8'h5A, 1'b0, 8'h5A, 1'b0);

        // Reset mid-word after the 4th serial bit.
        start[0] = 1'b1;
        din[0]   = 8'hC3;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_svalid", svalid[0], 1);
        rst_n = 1'b0;
        #1;
        chk("rst_en", en[0], 1);
        chk("rst_busy", busy[0], 0);
        chk("rst_svalid", svalid[0], 0);
        chk("rst_s", s[0], 0);
        chk("rst_d", d[0], 0);
        chk("rst_rx", rxword[0], 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_word(0, 8'h96, 1'b0, 8'h96, 1'b0);

        // START held high with DIN changing every cycle: accept every 12 cycles (gap 2).
        start[1] = 1'b1;
        asm_word = 8'd0;
        for (int c = 0; c < 36; c++) begin
            din[1]  = 8'($urandom);
            dins[c] = din[1];
            @(negedge clk);
            ph = c % 12;
            chk("hold_svalid", svalid[1], (ph >= 1 && ph <= 8) ? 1 : 0);
            chk("hold_busy", busy[1], (ph != 11) ? 1 : 0);
            if (ph >= 1 && ph <= 8) asm_word[8 - ph] = sout[1];
            if (ph == 8) chk("hold_word", asm_word, dins[c - 8]);
        end
        start[1] = 1'b0;

        // Randomized words against the reference model.
        for (int r = 0; r < 16; r++) begin
            u   = int'($urandom_range(0, 1));
            w   = 8'($urandom);
            flt = ($urandom_range(0, 3) == 0);
            rx  = flt ? (w & 8'hF7) : w;
            run_word(u, w, flt, rx, rx != w);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
